// File: rtl/vga_sync_receiver.sv
// Receive-side VGA timing recovery: rebuilds h/v position from incoming syncs,
// measures line/frame lengths and locks onto nominal timing.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        active_video,
    output logic        frame_start,
    output logic [11:0] h_meas,
    output logic [10:0] v_meas,
    output logic        locked,
    output logic        timing_error
);

    // state | meaning
    // SEARCH | no timing reference; waiting for the first qualified vsync
    // CHECK  | counting consecutive nominal frames
    // LOCKED | timing matches nominal; active window is reported
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

    localparam logic [12:0] H_LEN   = 13'(H_TOTAL);
    localparam logic [11:0] V_LEN   = 12'(V_TOTAL);
    localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic          hs_q, vs_q;
    logic [11:0]   h_cnt;
    logic [10:0]   v_cnt;
    logic          vpend;
    logic          line_bad;
    logic          frame_good_q;
    logic [1:0]    state;
    logic [GW-1:0] good_cnt;

    logic          hfall, vfall, service;
    logic [12:0]   h_len;
    logic [11:0]   v_len;
    logic          line_bad_now, frame_good, h_timeout;
    logic          h_in, v_in;

    always_comb begin
        hfall        = hs_q & ~hsync;
        vfall        = vs_q & ~vsync;
        service      = hfall & (vpend | vfall);
        h_len        = {1'b0, h_cnt} + 13'd1;
        v_len        = {1'b0, v_cnt} + 12'd1;
        line_bad_now = hfall & (h_len != H_LEN);
        // The line closing at this hfall belongs to the frame being evaluated.
        frame_good   = (v_len == V_LEN) & ~line_bad & ~line_bad_now;
        h_timeout    = (h_cnt == 12'hFFF);
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            h_cnt        <= '0;
            v_cnt        <= '0;
            h_meas       <= '0;
            v_meas       <= '0;
            vpend        <= 1'b0;
            line_bad     <= 1'b0;
            frame_start  <= 1'b0;
            frame_good_q <= 1'b0;
        end else begin
            hs_q         <= hsync;
            vs_q         <= vsync;
            frame_start  <= service;
            frame_good_q <= service & frame_good;
            if (hfall) begin
                h_meas <= h_len[11:0];
                h_cnt  <= '0;
            end else if (!h_timeout) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (service) begin
                v_meas   <= v_len[10:0];
                v_cnt    <= '0;
                vpend    <= 1'b0;
                line_bad <= 1'b0;
            end else begin
                if (hfall && v_cnt != 11'h7FF)
                    v_cnt <= v_cnt + 11'd1;
                if (vfall)
                    vpend <= 1'b1;
                if (line_bad_now)
                    line_bad <= 1'b1;
            end
        end
    end

    // Lock acquisition acts on the registered frame_start; loss of lock acts
    // directly at the offending hfall so it is reported one cycle later.
    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            timing_error <= 1'b0;
        end else begin
            timing_error <= 1'b0;
            if (h_timeout) begin
                state        <= SEARCH;
                good_cnt     <= '0;
                timing_error <= (state == LOCKED);
            end else begin
                case (state)
                    SEARCH: begin
                        if (frame_start) begin
                            state    <= CHECK;
                            good_cnt <= '0;
                        end
                    end
                    CHECK: begin
                        if (frame_start) begin
                            if (frame_good_q) begin
                                good_cnt <= good_cnt + 1'b1;
                                if (good_cnt == GOOD_LAST)
                                    state <= LOCKED;
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_bad_now || (service && !frame_good)) begin
                            state        <= SEARCH;
                            good_cnt     <= '0;
                            timing_error <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        locked       = (state == LOCKED);
        h_in         = (h_cnt >= H_START) && (h_cnt < H_END);
        v_in         = (v_cnt >= V_START) && (v_cnt < V_END);
        active_video = locked & h_in & v_in;
        pixel_x      = active_video ? 10'(h_cnt - H_START) : 10'd0;
        pixel_y      = active_video ? 10'(v_cnt - V_START) : 10'd0;
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a scaled-down raster so that
// several full frames fit in a short run; expectations come from raster arithmetic.
module tb_vga_sync_receiver;

    localparam int HT = 40;
    localparam int HS = 4;
    localparam int HB = 4;
    localparam int HA = 24;
    localparam int VT = 20;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 12;
    localparam int LF = 2;
    localparam int F  = HT * VT;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        hsync, vsync;
    logic [9:0]  pixel_x, pixel_y;
    logic        active_video, frame_start, locked, timing_error;
    logic [11:0] h_meas;
    logic [10:0] v_meas;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int n = 0;
    int voff = 0;
    bit idle = 1'b1;
    bit hs_force = 1'b0;
    bit rst_next = 1'b1;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .active_video(active_video),
        .frame_start(frame_start),
        .h_meas(h_meas),
        .v_meas(v_meas),
        .locked(locked),
        .timing_error(timing_error)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    function automatic bit pat_hs(input int p);
        return (p % HT) >= HS;
    endfunction

    function automatic bit pat_vs(input int p);
        return ((p + voff) % F) >= VS * HT;
    endfunction

    // Position p is driven during the current cycle; the DUT counters reflect p-1.
    function automatic void model_pix(input int p, output bit av, output int px, output int py);
        int r = (p + F - 1) % F;
        int h = r % HT;
        int v = r / HT;
        av = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        px = av ? h - (HS + HB) : 0;
        py = av ? v - (VS + VB) : 0;
    endfunction

    // Advance one pixel clock; returns at the falling edge with new inputs applied.
    task automatic tick();
        @(posedge clk_25MHz);
        #1;
        reset = rst_next;
        pos = (pos + 1) % F;
        n++;
        if (idle) begin
            hsync = 1'b1;
            vsync = 1'b1;
        end else begin
            hsync = hs_force ? 1'b1 : pat_hs(pos);
            vsync = pat_vs(pos);
        end
        @(negedge clk_25MHz);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        @(negedge clk_25MHz);
        @(negedge clk_25MHz);
        checks++; if (pixel_x !== 10'd0) begin errors++; $display("FAIL reset_pixel_x got=%0d exp=0", pixel_x); end
        checks++; if (pixel_y !== 10'd0) begin errors++; $display("FAIL reset_pixel_y got=%0d exp=0", pixel_y); end
        checks++; if (active_video !== 1'b0) begin errors++; $display("FAIL reset_active got=%0b exp=0", active_video); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%0b exp=0", frame_start); end
        checks++; if (h_meas !== 12'd0) begin errors++; $display("FAIL reset_h_meas got=%0d exp=0", h_meas); end
        checks++; if (v_meas !== 11'd0) begin errors++; $display("FAIL reset_v_meas got=%0d exp=0", v_meas); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        checks++; if (timing_error !== 1'b0) begin errors++; $display("FAIL reset_timing_error got=%0b exp=0", timing_error); end
        rst_next = 1'b0;
        repeat (3) tick();
        pos = F - 1;
        idle = 1'b0;
    endtask

    task automatic test_lock_acquire();
        int fs = 0;
        for (int i = 0; i < 4 * F && fs < 3; i++) begin
            tick();
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL lock_early locked=%0b fs=%0d", locked, fs); end
            if (frame_start === 1'b1) begin
                fs++;
                checks++;
                if (pos != 1) begin errors++; $display("FAIL fs_position got_pos=%0d exp=1", pos); end
                checks++;
                if (v_meas !== 11'((fs == 1) ? 1 : VT)) begin
                    errors++; $display("FAIL lock_v_meas fs=%0d got=%0d exp=%0d", fs, v_meas, (fs == 1) ? 1 : VT);
                end
                if (fs >= 2) begin
                    checks++;
                    if (h_meas !== 12'(HT)) begin errors++; $display("FAIL lock_h_meas got=%0d exp=%0d", h_meas, HT); end
                end
            end
        end
        checks++;
        if (fs != 3) begin
            errors++; $display("FAIL lock_timeout frame_starts=%0d exp=3", fs);
        end else begin
            tick();
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise got=%0b exp=1", locked); end
        end
    endtask

    task automatic test_window_scan();
        bit av;
        int px, py;
        for (int i = 0; i < F; i++) begin
            tick();
            model_pix(pos, av, px, py);
            checks++;
            if (active_video !== av) begin errors++; $display("FAIL scan_active pos=%0d got=%0b exp=%0b", pos, active_video, av); end
            checks++;
            if (pixel_x !== 10'(px)) begin errors++; $display("FAIL scan_pixel_x pos=%0d got=%0d exp=%0d", pos, pixel_x, px); end
            checks++;
            if (pixel_y !== 10'(py)) begin errors++; $display("FAIL scan_pixel_y pos=%0d got=%0d exp=%0d", pos, pixel_y, py); end
        end
    endtask

    task automatic test_vsync_alignment();
        int fs;
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 2 * F && pos != F / 2; i++) tick();
            voff = (mode == 0) ? $urandom_range(1, HT - 1) : 0;
            fs = 0;
            for (int i = 0; i < 2 * F; i++) begin
                tick();
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL vsync_lock mode=%0d got=%0b exp=1", mode, locked); end
                if (frame_start === 1'b1) begin
                    fs++;
                    checks++;
                    if (v_meas !== 11'(VT) || pos != 1) begin
                        errors++; $display("FAIL vsync_v_meas mode=%0d got=%0d exp=%0d pos=%0d", mode, v_meas, VT, pos);
                    end
                end
            end
            checks++;
            if (fs != 2) begin errors++; $display("FAIL vsync_fs_count mode=%0d voff=%0d got=%0d exp=2", mode, voff, fs); end
        end
    endtask

    task automatic test_short_line();
        int l = $urandom_range(2, VT - 4);
        int target = l * HT + HT / 2 - 1;
        int fs = 0;
        for (int i = 0; i < 2 * F && pos != target; i++) tick();
        pos = pos + 1;
        for (int i = 0; i < 2 * HT && pos != (l + 1) * HT; i++) tick();
        checks++;
        if (locked !== 1'b1 || timing_error !== 1'b0) begin
            errors++; $display("FAIL short_before locked=%0b terr=%0b exp=1/0", locked, timing_error);
        end
        tick();
        checks++;
        if (timing_error !== 1'b1) begin errors++; $display("FAIL short_terr got=%0b exp=1", timing_error); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL short_locked got=%0b exp=0", locked); end
        checks++;
        if (h_meas !== 12'(HT - 1)) begin errors++; $display("FAIL short_h_meas got=%0d exp=%0d", h_meas, HT - 1); end
        tick();
        checks++;
        if (timing_error !== 1'b0) begin errors++; $display("FAIL short_terr_once got=%0b exp=0", timing_error); end
        for (int i = 0; i < 5 * F && fs < 3; i++) begin
            tick();
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL short_relock_early fs=%0d", fs); end
            if (frame_start === 1'b1) fs++;
        end
        checks++;
        if (fs != 3) begin
            errors++; $display("FAIL short_relock_timeout fs=%0d exp=3", fs);
        end else begin
            tick();
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL short_relock got=%0b exp=1", locked); end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int n_pulse = -1;
        int n_exp;
        bit got = 1'b0;
        for (int i = 0; i < 2 * HT && (pos % HT) != HS + 3; i++) tick();
        n_exp = (n - (HS + 3)) + 4097;
        hs_force = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (timing_error === 1'b1) begin
                pulses++;
                n_pulse = n;
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
        checks++;
        if (n_pulse != n_exp) begin errors++; $display("FAIL timeout_cycle got=%0d exp=%0d", n_pulse, n_exp); end
        checks++;
        if (locked !== 1'b0 || active_video !== 1'b0) begin
            errors++; $display("FAIL timeout_locked locked=%0b active=%0b exp=0/0", locked, active_video);
        end
        hs_force = 1'b0;
        for (int i = 0; i < 8 * F && !got; i++) begin
            tick();
            got = (locked === 1'b1);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL timeout_relock got=0 exp=1"); end
    endtask

    task automatic test_reset_midframe();
        int lr = $urandom_range(6, 15);
        int col = $urandom_range(HS + 2, HT - 6);
        int p0, q;
        int fs = 0;
        for (int i = 0; i < 2 * F && pos != lr * HT + col; i++) tick();
        rst_next = 1'b1;
        tick();
        checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL rst_mid_pixel x=%0d y=%0d exp=0", pixel_x, pixel_y); end
        checks++; if (active_video !== 1'b0) begin errors++; $display("FAIL rst_mid_active got=%0b exp=0", active_video); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_mid_locked got=%0b exp=0", locked); end
        checks++; if (h_meas !== 12'd0 || v_meas !== 11'd0) begin errors++; $display("FAIL rst_mid_meas h=%0d v=%0d exp=0", h_meas, v_meas); end
        checks++; if (frame_start !== 1'b0 || timing_error !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses fs=%0b te=%0b exp=0", frame_start, timing_error); end
        tick();
        tick();
        rst_next = 1'b0;
        tick();
        p0 = pos;
        q = (p0 / HT + 1) * HT;
        for (int i = 0; i < 2 * HT && pos != q + 1; i++) tick();
        checks++;
        if (h_meas !== 12'(q - p0 + 1)) begin errors++; $display("FAIL rst_mid_h_restart got=%0d exp=%0d", h_meas, q - p0 + 1); end
        for (int i = 0; i < 5 * F && fs < 3; i++) begin
            tick();
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL rst_mid_relock_early fs=%0d", fs); end
            if (frame_start === 1'b1) begin
                fs++;
                if (fs == 1) begin
                    checks++;
                    if (v_meas !== 11'(VT - lr)) begin errors++; $display("FAIL rst_mid_v_meas got=%0d exp=%0d", v_meas, VT - lr); end
                end
            end
        end
        checks++;
        if (fs != 3) begin
            errors++; $display("FAIL rst_mid_relock_timeout fs=%0d exp=3", fs);
        end else begin
            tick();
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL rst_mid_relock got=%0b exp=1", locked); end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock_acquire();
        test_window_scan();
        test_vsync_alignment();
        test_short_line();
        test_window_scan();
        test_timeout();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the VGA timing chain. The block samples incoming active-low hsync/vsync and rebuilds the horizontal and vertical position counters. It measures line and frame lengths and locks when the measurements match the nominal 640x480@60 timing. It sits behind the display capture/loopback path and provides pixel coordinates, an active-video flag, and lock/error status to downstream logic.

## Interface
- H_TOTAL, 800, nominal clocks per line
- H_SYNC, 96, hsync low width (clocks)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, nominal lines per frame
- V_SYNC, 2, vsync low width (lines)
- V_BP, 33, vertical back porch (lines)
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required for lock
- clk_25MHz  in  1  pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hsync  in  1  active-low horizontal sync, synchronous to clk_25MHz
- vsync  in  1  active-low vertical sync, synchronous to clk_25MHz
- pixel_x  out  10  active column 0..H_ACTIVE-1, 0 when not active_video
- pixel_y  out  10  active row 0..V_ACTIVE-1, 0 when not active_video
- active_video  out  1  high when locked and inside the active window
- frame_start  out  1  one-cycle pulse per qualified vsync
- h_meas  out  12  length of the last completed line, in clocks
- v_meas  out  11  length of the last completed frame, in lines
- locked  out  1  timing matches nominal
- timing_error  out  1  one-cycle pulse on loss of lock

## Operation
- hs_q/vs_q hold the previous sample of hsync/vsync. Reset value is 1 (idle).
- hfall = hs_q & ~hsync. vfall = vs_q & ~vsync.
- h_cnt (12b): on hfall, h_meas <= h_cnt+1 and h_cnt <= 0. Otherwise h_cnt increments, saturating at 4095.
- v_cnt (11b): increments on each hfall, saturating at 2047.
- vfall sets vpend. vpend is serviced at the next hfall, or at the same cycle if vfall and hfall coincide.
- Servicing vpend: v_meas <= v_cnt+1, v_cnt <= 0, vpend <= 0, frame_start pulses.
- Line check: at each hfall, the line is bad if h_cnt+1 != H_TOTAL. A bad line sets line_bad. line_bad clears at each frame_start, after the frame has been evaluated.
- Frame good: v_cnt+1 == V_TOTAL, line_bad == 0, and the line ending at this hfall is not bad.
- FSM states are SEARCH, CHECK and LOCKED.
  - SEARCH: on frame_start, go to CHECK with good_cnt = 0. The partial frame is ignored.
  - CHECK: on a good frame_start, good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED. On a bad frame_start, good_cnt = 0 and stay in CHECK.
  - LOCKED: a bad line at any hfall, or a bad frame at frame_start, sends the FSM to SEARCH and pulses timing_error.
  - Timeout: h_cnt == 4095 in any state sends the FSM to SEARCH. timing_error pulses only if the FSM was in LOCKED.
- locked = (state == LOCKED).
- Active window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- When in the window: pixel_x = h_cnt-(H_SYNC+H_BP) and pixel_y = v_cnt-(V_SYNC+V_BP), truncated to 10 bits.

## Timing
- Reset values:
  - counters, h_meas, v_meas, good_cnt, vpend: 0
  - hs_q, vs_q: 1
  - state: SEARCH
  - all outputs: 0
- Edge latency: if hsync is first sampled low in cycle t, h_cnt == 0 in cycle t+1.
- frame_start is asserted in the cycle after the servicing hfall, together with the updated v_meas.
- pixel_x, pixel_y and active_video are combinational from the registered counters and state. They have zero added latency relative to h_cnt/v_cnt.
- Lock: with clean input, locked rises in the cycle after the (LOCK_FRAMES+1)th frame_start following reset.
- Loss of lock: timing_error and the drop of locked occur in the same cycle, one cycle after the offending hfall.
- Reset asserted mid-frame clears the block immediately. Lock must be re-acquired from SEARCH.

## Test plan
- Nominal 800x525 sync stream from reset → first frame_start ignored, locked high after the 3rd frame_start; h_meas=800, v_meas=525.
- Locked, one line shortened to 799 clocks → timing_error pulses once, locked=0, FSM in SEARCH, re-lock after 3 more clean frame_starts.
- Locked, scan the active window → active_video high with pixel_x 0..639, pixel_y 0..479; pixel_x=0 at h_cnt=144, pixel_y=0 at v_cnt=35; outputs 0 elsewhere.
- hsync held high 5000 clocks while locked → h_cnt saturates at 4095, timing_error pulses once, locked=0.
- vsync falling mid-line, and separately coincident with an hsync fall → each yields exactly one frame_start, v_meas=525.
- Reset asserted for 3 cycles mid-frame while locked → all outputs 0 immediately; counters restart; lock requires 3 new frame_starts.
